pito_test_monitor: RTL

- Synthesizable end-of-test monitor for multi-hart pito testbenches; instantiated beside rv32_core in the top-level bench.
- Decodes tohost-style exit writes per hart, tracks pass/fail per hart, and counts cycles.
- Enforces a programmable watchdog that replaces the fixed wall-clock timeout thread.
- Generalised to NUM_HARTS channels, an enable mask, a configurable timeout, and restartable runs.

---
 rtl/pito_test_pkg.sv | 29 ++
 rtl/pito_sat_counter.sv | 28 ++
 rtl/pito_test_monitor.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pito_test_pkg.sv
// Shared types and helpers for the pito end-of-test monitor.
//   test_state_e  : monitor FSM states
//   tohost_t      : decoded tohost write (exit flag + 31-bit exit code)
//   decode_tohost : splits raw tohost data into exit flag and code
package pito_test_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone,
    StTimeout
  } test_state_e;

  localparam int unsigned TOHOST_EXIT_BIT = 0;
  localparam int unsigned TOHOST_CODE_LSB = 1;

  typedef struct packed {
    logic        exit_flag;
    logic [30:0] code;
  } tohost_t;

  function automatic tohost_t decode_tohost(input logic [31:0] data);
    tohost_t w_dec;
    w_dec.exit_flag = data[TOHOST_EXIT_BIT];
    w_dec.code      = data[31:TOHOST_CODE_LSB];
    return w_dec;
  endfunction

endpackage

// File: rtl/pito_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, synchronous active-high reset
//   i_clear  : zero the count (wins over i_en)
//   i_en     : count up by one, sticking at all-ones
//   o_count  : current count
module pito_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pito_test_monitor.sv
// End-of-test monitor for multi-hart pito benches. Decodes tohost exit writes per
// hart, records pass/fail per hart and runs a cycle-count watchdog.
//   clk, rst            : clock, synchronous active-high reset
//   start_i, hart_en_i  : begin a run with the given set of required harts
//   th_valid_i/hart/data: tohost write port (data[0]=exit, data[31:1]=code)
//   busy_o/finished_o   : run in progress / run ended
//   pass_o, timeout_o   : all enabled harts exited with 0 / watchdog expired
//   done_mask_o, fail_mask_o, first_fail_hart_o, first_fail_code_o : run results
//   cycles_o            : saturating cycle count since start
module pito_test_monitor
  import pito_test_pkg::*;
#(
  parameter int unsigned NUM_HARTS      = 8,
  parameter int unsigned CYCLE_W        = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned HART_W         = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [NUM_HARTS-1:0] hart_en_i,
  input  logic                 th_valid_i,
  input  logic [HART_W-1:0]    th_hart_i,
  input  logic [31:0]          th_data_i,
  output logic                 busy_o,
  output logic                 finished_o,
  output logic                 pass_o,
  output logic                 timeout_o,
  output logic [NUM_HARTS-1:0] done_mask_o,
  output logic [NUM_HARTS-1:0] fail_mask_o,
  output logic [HART_W-1:0]    first_fail_hart_o,
  output logic [30:0]          first_fail_code_o,
  output logic [CYCLE_W-1:0]   cycles_o
);

  test_state_e          r_state, w_state_next;
  logic [NUM_HARTS-1:0] r_en, w_en_next;
  logic [NUM_HARTS-1:0] r_done, w_done_next;
  logic [NUM_HARTS-1:0] r_fail, w_fail_next;
  logic [HART_W-1:0]    r_ff_hart, w_ff_hart_next;
  logic [30:0]          r_ff_code, w_ff_code_next;

  logic [CYCLE_W-1:0]   w_cycles;
  logic [NUM_HARTS-1:0] w_hart_oh;
  logic                 w_start_acc;
  logic                 w_exit;
  logic                 w_last_cycle;
  logic                 w_count_en;
  tohost_t              w_dec;

  assign w_dec       = decode_tohost(th_data_i);
  // Out-of-range hart ids shift the one past the top bit, giving an all-zero select.
  assign w_hart_oh   = NUM_HARTS'(1) << th_hart_i;
  assign w_start_acc = start_i && (r_state != StRun);
  assign w_exit      = th_valid_i && (r_state == StRun) && w_dec.exit_flag &&
                       ((w_hart_oh & r_en & ~r_done) != '0);
  assign w_last_cycle = (w_cycles == CYCLE_W'(TIMEOUT_CYCLES - 1));
  assign w_count_en   = (r_state == StRun);

  pito_sat_counter #(
    .WIDTH(CYCLE_W)
  ) u_cycles (
    .clk    (clk),
    .rst    (rst),
    .i_clear(w_start_acc),
    .i_en   (w_count_en),
    .o_count(w_cycles)
  );

  always_comb begin
    w_state_next   = r_state;
    w_en_next      = r_en;
    w_done_next    = r_done;
    w_fail_next    = r_fail;
    w_ff_hart_next = r_ff_hart;
    w_ff_code_next = r_ff_code;
    unique case (r_state)
      StRun: begin
        if (w_exit) begin
          w_done_next = r_done | w_hart_oh;
          if (w_dec.code != '0) begin
            w_fail_next = r_fail | w_hart_oh;
            if (r_fail == '0) begin
              w_ff_hart_next = th_hart_i;
              w_ff_code_next = w_dec.code;
            end
          end
        end
        // Completion wins over the watchdog when both land on the same cycle.
        if ((w_done_next & r_en) == r_en) begin
          w_state_next = StDone;
        end else if (w_last_cycle) begin
          w_state_next = StTimeout;
        end
      end
      StIdle, StDone, StTimeout: begin
        if (w_start_acc) begin
          w_en_next      = hart_en_i;
          w_done_next    = '0;
          w_fail_next    = '0;
          w_ff_hart_next = '0;
          w_ff_code_next = '0;
          w_state_next   = (hart_en_i == '0) ? StDone : StRun;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_en      <= '0;
      r_done    <= '0;
      r_fail    <= '0;
      r_ff_hart <= '0;
      r_ff_code <= '0;
    end else begin
      r_state   <= w_state_next;
      r_en      <= w_en_next;
      r_done    <= w_done_next;
      r_fail    <= w_fail_next;
      r_ff_hart <= w_ff_hart_next;
      r_ff_code <= w_ff_code_next;
    end
  end

  assign busy_o            = (r_state == StRun);
  assign finished_o        = (r_state == StDone) || (r_state == StTimeout);
  assign timeout_o         = (r_state == StTimeout);
  assign pass_o            = (r_state == StDone) && (r_fail == '0) && (r_en != '0);
  assign done_mask_o       = r_done;
  assign fail_mask_o       = r_fail;
  assign first_fail_hart_o = r_ff_hart;
  assign first_fail_code_o = r_ff_code;
  assign cycles_o          = w_cycles;

endmodule
